// File: rtl/seq_det_ctrl.sv
// Word-level sequencer for a serial "101" detector.
// Accepts a word, resets the detector, shifts the word out MSB-first and
// counts the detector hits that belong to that word. Reports the count with
// a one-cycle done strobe.
//
// Handshake: a word is accepted on a rising edge where word_valid_in and
// word_ready_out are both high. word_ready_out is high only in IDLE. The
// producer may change or drop word_valid_in at any time while ready is low.
// Those values are ignored.
module seq_det_ctrl #(
  parameter int W       = 8,
  parameter int HIT_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic             clock_in,
  input  logic             rst_in,
  input  logic [W-1:0]     word_in,
  input  logic             word_valid_in,
  output logic             word_ready_out,
  output logic             det_data_out,
  output logic             det_rst_out,
  input  logic             det_hit_in,
  output logic [CNT_W-1:0] hit_count_out,
  output logic             done_out,
  output logic             busy_out,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // k counts cycles from SHIFT cycle 0 through the end of DRAIN.
  localparam int KW = $clog2(W + HIT_LAT + 1);
  localparam logic [KW-1:0]    K_SHIFT_LAST = KW'(W - 1);
  localparam logic [KW-1:0]    K_LAST       = KW'(W + HIT_LAT - 1);
  localparam logic [KW-1:0]    K_FIRST      = KW'(HIT_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state_q;
  state_t           state_d;
  logic [KW-1:0]    k_q;
  logic [W-1:0]     sr_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_inc;
  logic             accept;
  logic             sample;

  assign accept    = word_valid_in & word_ready_out;
  assign dbg_state = state_q;

  // A hit belongs to the current word only when it arrives within the W-cycle
  // window that starts HIT_LAT cycles after the first bit.
  assign sample  = ((state_q == S_SHIFT) || (state_q == S_DRAIN)) && (k_q >= K_FIRST);
  assign acc_inc = (sample && det_hit_in && (acc_q != CNT_MAX)) ? acc_q + 1'b1 : acc_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CLR;
      S_CLR:   state_d = S_SHIFT;
      S_SHIFT: if (k_q == K_SHIFT_LAST) state_d = S_DRAIN;
      S_DRAIN: if (k_q == K_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs, all decoded from the state being entered.
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      k_q            <= '0;
      sr_q           <= '0;
      acc_q          <= '0;
      det_data_out   <= 1'b0;
      det_rst_out    <= 1'b1;
      word_ready_out <= 1'b1;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      hit_count_out  <= '0;
    end else begin
      det_rst_out    <= (state_d == S_CLR);
      word_ready_out <= (state_d == S_IDLE);
      busy_out       <= (state_d != S_IDLE);
      done_out       <= (state_d == S_DONE);

      if ((state_q == S_IDLE) && accept) begin
        sr_q  <= word_in;
        acc_q <= '0;
      end

      if ((state_q == S_SHIFT) || (state_q == S_DRAIN)) begin
        k_q   <= k_q + 1'b1;
        acc_q <= acc_inc;
      end else begin
        k_q <= '0;
      end

      if (state_d == S_SHIFT) begin
        det_data_out <= sr_q[W-1];
        sr_q         <= {sr_q[W-2:0], 1'b0};
      end else begin
        det_data_out <= 1'b0;
      end

      // The last window sample lands on the edge entering DONE, so take acc_inc.
      if (state_d == S_DONE) hit_count_out <= acc_inc;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: two instances (CNT_W=4 and CNT_W=2) share the word
// stream, and each one drives its own behavioural overlapping "101" detector.
// A cycle-level monitor predicts every output from the word timeline.
module tb_seq_det_ctrl;

  localparam int W       = 8;
  localparam int HIT_LAT = 1;

  logic         clk = 1'b0;
  logic         rst_in;
  logic [W-1:0] word_in;
  logic         word_valid_in;

  logic       ready_a, data_a, drst_a, hit_a, done_a, busy_a;
  logic [3:0] cnt_a;
  logic [2:0] st_a;
  logic       ready_b, data_b, drst_b, hit_b, done_b, busy_b;
  logic [1:0] cnt_b;
  logic [2:0] st_b;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  seq_det_ctrl #(.W(W), .HIT_LAT(HIT_LAT), .CNT_W(4)) dut_a (
    .clock_in(clk), .rst_in(rst_in), .word_in(word_in), .word_valid_in(word_valid_in),
    .word_ready_out(ready_a), .det_data_out(data_a), .det_rst_out(drst_a),
    .det_hit_in(hit_a), .hit_count_out(cnt_a), .done_out(done_a), .busy_out(busy_a),
    .dbg_state(st_a)
  );

  seq_det_ctrl #(.W(W), .HIT_LAT(HIT_LAT), .CNT_W(2)) dut_b (
    .clock_in(clk), .rst_in(rst_in), .word_in(word_in), .word_valid_in(word_valid_in),
    .word_ready_out(ready_b), .det_data_out(data_b), .det_rst_out(drst_b),
    .det_hit_in(hit_b), .hit_count_out(cnt_b), .done_out(done_b), .busy_out(busy_b),
    .dbg_state(st_b)
  );

  // ---------------- detector models: hit when last three bits are 1,0,1 ----------------
  logic [2:0] hist_a = '0, hist_b = '0;
  int         seen_a = 0,  seen_b = 0;

  always @(posedge clk) begin
    if (drst_a) begin hist_a <= '0; seen_a <= 0; end
    else begin hist_a <= {hist_a[1:0], data_a}; if (seen_a < 3) seen_a <= seen_a + 1; end
    if (drst_b) begin hist_b <= '0; seen_b <= 0; end
    else begin hist_b <= {hist_b[1:0], data_b}; if (seen_b < 3) seen_b <= seen_b + 1; end
  end
  assign hit_a = (seen_a == 3) && (hist_a == 3'b101);
  assign hit_b = (seen_b == 3) && (hist_b == 3'b101);

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: number of (overlapping) 101 windows in the word, MSB first, saturated.
  function automatic int count101(input logic [W-1:0] w, input int max);
    int c = 0;
    for (int i = 0; i <= W - 3; i++)
      if (w[W-1-i] && !w[W-2-i] && w[W-3-i]) c++;
    return (c > max) ? max : c;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [7:0]   exp_q[$];      // {2'b0, count for CNT_W=2, count for CNT_W=4}
  int           cyc      = 0;
  bit           started  = 0;
  bit           rst_prev = 0;
  bit           act_on   = 0;
  int           act_acc  = 0;
  logic [W-1:0] act_word = '0;
  logic [3:0]   last_a   = '0;
  logic [1:0]   last_b   = '0;

  always @(negedge clk) begin
    bit   in_act, e_busy, e_ready, e_drst, e_done, e_data;
    int   rel;
    logic [7:0] e;
    cyc++;
    in_act  = act_on && (cyc > act_acc);
    rel     = cyc - act_acc;
    e_busy  = in_act;
    e_ready = !in_act;
    e_drst  = rst_prev || (in_act && rel == 1);
    e_done  = in_act && (rel == W + HIT_LAT + 2);
    e_data  = (in_act && rel >= 2 && rel <= W + 1) ? act_word[W-1-(rel-2)] : 1'b0;
    if (started) begin
      if (e_done) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          last_a = e[3:0];
          last_b = e[5:4];
        end else check("scoreboard_empty", 1, 0);
      end
      check("ready_a", ready_a, e_ready);  check("ready_b", ready_b, e_ready);
      check("busy_a",  busy_a,  e_busy);   check("busy_b",  busy_b,  e_busy);
      check("det_rst_a", drst_a, e_drst);  check("det_rst_b", drst_b, e_drst);
      check("done_a",  done_a,  e_done);   check("done_b",  done_b,  e_done);
      check("data_a",  data_a,  e_data);   check("data_b",  data_b,  e_data);
      check("count_a", cnt_a,   last_a);   check("count_b", cnt_b,   last_b);
      if (e_done) act_on = 0;
    end
    if (rst_in) begin
      started = 1;
      act_on  = 0;
      last_a  = '0;
      last_b  = '0;
      exp_q.delete();
    end else if (started && word_valid_in && e_ready) begin
      act_on   = 1;
      act_acc  = cyc;
      act_word = word_in;
      exp_q.push_back({2'b00, 2'(count101(word_in, 3)), 4'(count101(word_in, 15))});
    end
    rst_prev = rst_in;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] w);
    int t = 0;
    word_in = w;
    word_valid_in = 1'b1;
    @(negedge clk);
    while (!ready_a && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    word_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while ((busy_a || !ready_a) && t < 100);
    if (t >= 100) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    logic [W-1:0] dir_words[5];
    dir_words = '{8'b1011_0101, 8'h00, 8'b1010_1010, 8'hFF, 8'b0000_0101};

    rst_in = 1'b1; word_in = '0; word_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // directed words
    foreach (dir_words[i]) begin
      send_word(dir_words[i]);
      wait_idle();
    end

    // back-to-back with valid held high
    word_in = 8'b1000_0000; word_valid_in = 1'b1;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!ready_a && gap < 100);
    @(posedge clk); #1;
    word_in = 8'b0100_0000;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!ready_a && gap < 100);
    check("b2b_gap", gap, 12);
    @(posedge clk); #1;
    word_valid_in = 1'b0;
    wait_idle();

    // reset in SHIFT cycle 4 abandons the word
    send_word(8'b1011_0101);
    repeat (5) @(posedge clk);
    #1 rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    @(negedge clk);
    check("midrst_state_a", st_a, 0);
    check("midrst_state_b", st_b, 0);
    @(posedge clk); #1;
    send_word(8'b1011_0101);
    wait_idle();

    // random words, with valid and data toggling freely while busy
    for (int i = 0; i < 600; i++) begin
      word_valid_in = ($urandom_range(0, 2) == 0);
      word_in = W'($urandom);
      @(posedge clk); #1;
    end
    word_valid_in = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
